// File: rtl/ht1080z_pkg.sv
// Types and constants shared by the ht1080z program loaders.
package ht1080z_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_TYPE,
    GET_LEN,
    ADDR_LO,
    ADDR_HI,
    DATA,
    SKIP,
    XFER_LO,
    XFER_HI,
    DONE
  } cmd_state_t;

  localparam logic [7:0] CMD_BLK_LOAD = 8'h01;
  localparam logic [7:0] CMD_BLK_XFER = 8'h02;

endpackage

// File: rtl/cmd_loader.sv
// Turns a TRS-80 /CMD file streamed over the hps_io ioctl bus into memory
// writes for the ht1080z download port, and captures the program entry point.
module cmd_loader
  import ht1080z_pkg::*;
#(
  parameter logic [7:0] CMD_INDEX  = 8'd2,
  parameter int         WR_STRETCH = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic        loader_en,
  output logic        loader_wr,
  output logic [15:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic [15:0] exec_addr,
  output logic        exec_valid,
  output logic        load_error
);

  localparam int             WCW      = $clog2(WR_STRETCH + 2);
  localparam logic [WCW-1:0] WAIT_LEN = WCW'(WR_STRETCH + 1);

  cmd_state_t     state, byte_state, state_next;
  logic           dl_q;
  logic           dl_rise, dl_fall, start;
  logic [7:0]     blk_type;
  logic [8:0]     count;
  logic [WCW-1:0] wait_cnt;

  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign start      = (state == IDLE) && dl_rise && (ioctl_index == CMD_INDEX);
  assign ioctl_wait = (wait_cnt != '0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // byte_state is where the parser lands after the current byte, which the
  // end-of-download rule needs when the last byte and the falling edge coincide.
  always_comb begin
    byte_state = state;
    if (ioctl_wr) begin
      case (state)
        GET_TYPE: byte_state = GET_LEN;
        GET_LEN: begin
          if (blk_type == CMD_BLK_LOAD)      byte_state = ADDR_LO;
          else if (blk_type == CMD_BLK_XFER) byte_state = XFER_LO;
          else                               byte_state = SKIP;
        end
        ADDR_LO: byte_state = ADDR_HI;
        ADDR_HI: byte_state = (count == 9'd0) ? GET_TYPE : DATA;
        DATA:    byte_state = (count == 9'd1) ? GET_TYPE : DATA;
        SKIP:    byte_state = (count == 9'd1) ? GET_TYPE : SKIP;
        XFER_LO: byte_state = XFER_HI;
        XFER_HI: byte_state = DONE;
        default: byte_state = state;
      endcase
    end
    state_next = byte_state;
    if (start)                        state_next = GET_TYPE;
    else if (state != IDLE && dl_fall) state_next = IDLE;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q        <= 1'b0;
      blk_type    <= 8'h00;
      count       <= 9'd0;
      wait_cnt    <= '0;
      loader_en   <= 1'b0;
      loader_wr   <= 1'b0;
      loader_addr <= 16'h0000;
      loader_data <= 8'h00;
      exec_addr   <= 16'h0000;
      exec_valid  <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      loader_wr <= 1'b0;
      if (wait_cnt != '0) wait_cnt <= wait_cnt - WCW'(1);
      if (loader_wr)      loader_addr <= loader_addr + 16'd1;

      if (start) begin
        loader_en  <= 1'b1;
        exec_valid <= 1'b0;
        load_error <= 1'b0;
      end

      if (ioctl_wr) begin
        case (state)
          GET_TYPE: blk_type <= ioctl_data;
          // Load lengths below 3 wrap past 256; the two address bytes are part of L.
          GET_LEN: begin
            if (blk_type == CMD_BLK_LOAD)
              count <= (ioctl_data < 8'd3) ? {1'b0, ioctl_data} + 9'd254
                                           : {1'b0, ioctl_data} - 9'd2;
            else
              count <= (ioctl_data == 8'd0) ? 9'd256 : {1'b0, ioctl_data};
          end
          ADDR_LO: loader_addr[7:0]  <= ioctl_data;
          ADDR_HI: loader_addr[15:8] <= ioctl_data;
          DATA: begin
            loader_data <= ioctl_data;
            loader_wr   <= 1'b1;
            wait_cnt    <= WAIT_LEN;
            count       <= count - 9'd1;
          end
          SKIP:    count <= count - 9'd1;
          XFER_LO: exec_addr[7:0]  <= ioctl_data;
          XFER_HI: exec_addr[15:8] <= ioctl_data;
          default: ;
        endcase
      end

      if (state != IDLE && dl_fall) begin
        loader_en  <= 1'b0;
        wait_cnt   <= '0;
        exec_valid <= (byte_state == DONE);
        load_error <= !((byte_state == DONE) || (byte_state == GET_TYPE));
      end
    end
  end

endmodule

// File: tb/tb_cmd_loader.sv
// Randomised and directed bench for cmd_loader, checked against a byte-level
// /CMD file interpreter.
module tb_cmd_loader;

  localparam int WR_STRETCH = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic        loader_en;
  logic        loader_wr;
  logic [15:0] loader_addr;
  logic [7:0]  loader_data;
  logic [15:0] exec_addr;
  logic        exec_valid;
  logic        load_error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stim[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [15:0] got_addr[$];
  logic [7:0]  got_data[$];
  logic [15:0] exp_exec;
  bit          exp_valid, exp_err;
  bit          activity;
  bit          wait_abort = 1'b0;
  int          wait_run   = 0;

  cmd_loader #(.CMD_INDEX(8'd2), .WR_STRETCH(WR_STRETCH)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .loader_en      (loader_en),
    .loader_wr      (loader_wr),
    .loader_addr    (loader_addr),
    .loader_data    (loader_data),
    .exec_addr      (exec_addr),
    .exec_valid     (exec_valid),
    .load_error     (load_error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Records every write strobe and checks the length of each wait window.
  always @(negedge clk_sys) begin
    if (loader_wr) begin
      got_addr.push_back(loader_addr);
      got_data.push_back(loader_data);
      checkOutput("wait_during_wr", {31'd0, ioctl_wait}, 32'd1);
    end
    if (loader_en || loader_wr || ioctl_wait) activity = 1'b1;
    if (ioctl_wait) wait_run++;
    else if (wait_run != 0) begin
      if (!wait_abort) checkOutput("wait_len", wait_run, 1 + WR_STRETCH);
      wait_run = 0;
    end
  end

  // Reference interpreter: walks the file block by block.
  task automatic runModel();
    int i, n, cnt;
    logic [7:0]  typ, len;
    logic [15:0] a;
    exp_addr.delete();
    exp_data.delete();
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    n = stim.size();
    i = 0;
    while (i < n && !exp_err && !exp_valid) begin
      typ = stim[i];
      if (i + 2 > n) begin exp_err = 1'b1; break; end
      len = stim[i+1];
      i += 2;
      if (typ == 8'h01) begin
        cnt = (len < 8'd3) ? int'(len) + 256 - 2 : int'(len) - 2;
        if (i + 2 > n) begin exp_err = 1'b1; break; end
        a = {stim[i+1], stim[i]};
        i += 2;
        for (int k = 0; k < cnt; k++) begin
          if (i >= n) begin exp_err = 1'b1; break; end
          exp_addr.push_back(a + 16'(k));
          exp_data.push_back(stim[i]);
          i++;
        end
      end else if (typ == 8'h02) begin
        if (i + 2 > n) begin exp_err = 1'b1; break; end
        exp_exec  = {stim[i+1], stim[i]};
        exp_valid = 1'b1;
      end else begin
        cnt = (len == 8'd0) ? 256 : int'(len);
        if (i + cnt > n) begin exp_err = 1'b1; break; end
        i += cnt;
      end
    end
  endtask

  task automatic buildRandom();
    int nblk, len, cnt;
    bit long_used;
    logic [15:0] a;
    stim.delete();
    long_used = 1'b0;
    nblk = $urandom_range(1, 4);
    for (int b = 0; b < nblk; b++) begin
      if ($urandom_range(0, 9) < 6) begin
        if (!long_used && $urandom_range(0, 7) == 0) begin
          len = $urandom_range(0, 2);
          long_used = 1'b1;
        end else len = $urandom_range(3, 12);
        a = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
        cnt = (len < 3) ? len + 254 : len - 2;
        stim.push_back(8'h01);
        stim.push_back(8'(len));
        stim.push_back(a[7:0]);
        stim.push_back(a[15:8]);
        repeat (cnt) stim.push_back(8'($urandom));
      end else begin
        len = $urandom_range(0, 5);
        if (len == 0 && long_used) len = 4;
        if (len == 0) long_used = 1'b1;
        cnt = (len == 0) ? 256 : len;
        stim.push_back(8'($urandom_range(3, 255)));
        stim.push_back(8'(len));
        repeat (cnt) stim.push_back(8'($urandom));
      end
    end
    if ($urandom_range(0, 1) == 1) begin
      stim.push_back(8'h02);
      stim.push_back(8'($urandom));
      stim.push_back(8'($urandom));
      stim.push_back(8'($urandom));
      repeat ($urandom_range(0, 3)) stim.push_back(8'($urandom));
    end
    if ($urandom_range(0, 4) == 0 && stim.size() > 2)
      repeat ($urandom_range(1, 2)) void'(stim.pop_back());
  endtask

  // Called at a negedge; honours ioctl_wait before strobing the next byte.
  task automatic sendByte(input logic [7:0] b);
    int guard;
    guard = 0;
    while (ioctl_wait && guard < 50) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 50) checkOutput("wait_timeout", 32'd1, 32'd0);
    ioctl_wr   = 1'b1;
    ioctl_data = b;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    repeat ($urandom_range(0, 1)) @(negedge clk_sys);
  endtask

  task automatic startDownload(input logic [7:0] idx);
    got_addr.delete();
    got_data.delete();
    activity = 1'b0;
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    checkOutput($sformatf("loader_en_on_idx%0d", idx), {31'd0, loader_en}, {31'd0, idx == 8'd2});
  endtask

  task automatic endDownload();
    repeat (4) @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic applyStimulus(input logic [7:0] idx);
    startDownload(idx);
    foreach (stim[k]) sendByte(stim[k]);
    endDownload();
  endtask

  task automatic checkDownload(input string tag);
    int n;
    checkOutput({tag, ":nwr"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s:addr%0d", tag, k), {16'd0, got_addr[k]}, {16'd0, exp_addr[k]});
      checkOutput($sformatf("%s:data%0d", tag, k), {24'd0, got_data[k]}, {24'd0, exp_data[k]});
    end
    checkOutput({tag, ":exec_valid"}, {31'd0, exec_valid}, {31'd0, exp_valid});
    checkOutput({tag, ":load_error"}, {31'd0, load_error}, {31'd0, exp_err});
    if (exp_valid) checkOutput({tag, ":exec_addr"}, {16'd0, exec_addr}, {16'd0, exp_exec});
    checkOutput({tag, ":loader_en"}, {31'd0, loader_en}, 32'd0);
    checkOutput({tag, ":ioctl_wait"}, {31'd0, ioctl_wait}, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ":loader_en"},   {31'd0, loader_en},   32'd0);
    checkOutput({tag, ":loader_wr"},   {31'd0, loader_wr},   32'd0);
    checkOutput({tag, ":ioctl_wait"},  {31'd0, ioctl_wait},  32'd0);
    checkOutput({tag, ":loader_addr"}, {16'd0, loader_addr}, 32'd0);
    checkOutput({tag, ":loader_data"}, {24'd0, loader_data}, 32'd0);
    checkOutput({tag, ":exec_addr"},   {16'd0, exec_addr},   32'd0);
    checkOutput({tag, ":exec_valid"},  {31'd0, exec_valid},  32'd0);
    checkOutput({tag, ":load_error"},  {31'd0, load_error},  32'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_data     = 8'd0;
    @(negedge clk_sys);
    checkAllZero("reset");
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    stim = '{8'h01, 8'h05, 8'h00, 8'h60, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h60};
    runModel();
    applyStimulus(8'd2);
    checkDownload("basic");
    checkOutput("basic:exec_addr_const", {16'd0, exec_addr}, 32'h6000);
    checkOutput("basic:nwr_const", got_addr.size(), 32'd3);

    stim = '{8'h01, 8'h00, 8'h00, 8'h70};
    repeat (254) stim.push_back(8'($urandom));
    runModel();
    applyStimulus(8'd2);
    checkDownload("len00");
    checkOutput("len00:count", got_addr.size(), 32'd254);
    if (got_addr.size() > 0) checkOutput("len00:last", {16'd0, got_addr[$]}, 32'h70FD);

    stim = '{8'h01, 8'h02, 8'h00, 8'h70};
    repeat (256) stim.push_back(8'($urandom));
    runModel();
    applyStimulus(8'd2);
    checkDownload("len02");
    checkOutput("len02:count", got_addr.size(), 32'd256);
    if (got_addr.size() > 0) checkOutput("len02:last", {16'd0, got_addr[$]}, 32'h70FF);

    stim = '{8'h05, 8'h03, 8'h41, 8'h42, 8'h43, 8'h01, 8'h03, 8'hFF, 8'hFF, 8'h11};
    runModel();
    applyStimulus(8'd2);
    checkDownload("wrap");
    checkOutput("wrap:count", got_addr.size(), 32'd1);
    checkOutput("wrap:next_addr", {16'd0, loader_addr}, 32'h0000);

    stim = '{8'h01, 8'h06, 8'h00, 8'h50, 8'h01, 8'h02};
    runModel();
    applyStimulus(8'd2);
    checkDownload("trunc");
    checkOutput("trunc:load_error_const", {31'd0, load_error}, 32'd1);

    stim = '{8'h01, 8'h05, 8'h00, 8'h60, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h60};
    applyStimulus(8'd1);
    checkOutput("cas:activity", {31'd0, activity}, 32'd0);
    checkOutput("cas:nwr", got_addr.size(), 32'd0);

    // Reset lands while a data write's wait window is still open.
    stim = '{8'h01, 8'h10, 8'h00, 8'h40};
    startDownload(8'd2);
    foreach (stim[k]) sendByte(stim[k]);
    ioctl_wr   = 1'b1;
    ioctl_data = 8'h55;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    checkOutput("midrst:wait_before", {31'd0, ioctl_wait}, 32'd1);
    @(posedge clk_sys);
    #2;
    wait_abort = 1'b1;
    reset_n    = 1'b0;
    #1;
    checkAllZero("midrst");
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    wait_abort = 1'b0;

    stim = '{8'h01, 8'h05, 8'h00, 8'h60, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h60};
    runModel();
    applyStimulus(8'd2);
    checkDownload("after_rst");

    for (int it = 0; it < 15; it++) begin
      buildRandom();
      runModel();
      applyStimulus(8'd2);
      checkDownload($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
